// File: rtl/dbus_uart_tx.sv
// Data-bus mapped 8N1 UART transmitter: TXDATA/STATUS/DIVISOR/CTRL window, byte FIFO, serializer.
// Optional TX-done interrupt built when DBUS_UART_TX_IRQ_EN is defined.
module dbus_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
   parameter int          FIFO_DEPTH   = 8,
   parameter int          CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic        data_we,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   output logic        hit,
   output logic        uart_tx,
   output logic        irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e        state_q, state_d;
   logic [7:0]    fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   div_q, div_d, div_lat_q, div_lat_d, baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, irq_en_q, irq_en_d, irq_q, irq_d;

   logic       wr_en, push, push_ok, launch, baud_end, empty, full, busy;
   logic [1:0] reg_sel;
   logic [3:0] cnt4;
   logic       unused_ok;

   assign hit      = data_addr[31:4] == BASE_ADDR[31:4];
   assign reg_sel  = data_addr[3:2];
   assign wr_en    = data_we && hit;
   assign push     = wr_en && (reg_sel == 2'd0);
   assign empty    = count_q == '0;
   assign full     = count_q == CNT_FULL;
   assign busy     = state_q != S_IDLE;
   assign baud_end = baud_q == (div_lat_q - 16'd1);
   // A new frame starts from IDLE or straight out of the last stop-bit clock.
   assign launch   = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
   assign push_ok  = push && (!full || launch);
   assign cnt4     = 4'(count_q);
   assign unused_ok = &{1'b0, data_wdata[31:16], data_addr[1:0]};

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      baud_d    = baud_q + 16'd1;
      div_lat_d = div_lat_q;
      tx_d      = tx_q;
      unique case (state_q)
         S_IDLE: begin
            baud_d = '0;
            tx_d   = 1'b1;
         end
         S_START: if (baud_end) begin
            state_d = S_DATA;
            baud_d  = '0;
            tx_d    = shift_q[0];
         end
         S_DATA: if (baud_end) begin
            baud_d = '0;
            if (bit_q == 3'd7) begin
               state_d = S_STOP;
               tx_d    = 1'b1;
            end else begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               tx_d    = shift_q[1];
            end
         end
         S_STOP: if (baud_end) begin
            state_d = S_IDLE;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
      if (launch) begin
         state_d   = S_START;
         shift_d   = fifo_mem_q[rd_ptr_q];
         div_lat_d = div_q;
         bit_d     = '0;
         baud_d    = '0;
         tx_d      = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = launch  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      unique case ({push_ok, launch})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (push && full && !launch)
         ovf_d = 1'b1;
      else if (wr_en && (reg_sel == 2'd1) && data_wdata[8])
         ovf_d = 1'b0;
      div_d = div_q;
      if (wr_en && (reg_sel == 2'd2))
         div_d = (data_wdata[15:0] == 16'd0) ? 16'd1 : data_wdata[15:0];
`ifdef DBUS_UART_TX_IRQ_EN
      irq_en_d = (wr_en && (reg_sel == 2'd3)) ? data_wdata[0] : irq_en_q;
      // Computed from next-state so the flop rises as the stop bit ends and drops on the push edge.
      irq_d    = irq_en_d && (state_d == S_IDLE) && (count_d == '0);
`else
      irq_en_d = 1'b0;
      irq_d    = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem_q[wr_ptr_q] <= data_wdata[7:0];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         div_q     <= 16'(CLKS_PER_BIT);
         div_lat_q <= 16'(CLKS_PER_BIT);
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         irq_en_q  <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         div_q     <= div_d;
         div_lat_q <= div_lat_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         irq_en_q  <= irq_en_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      data_rdata = '0;
      if (data_re && hit) begin
         unique case (reg_sel)
            2'd0: data_rdata = '0;
            2'd1: data_rdata = {23'd0, ovf_q, cnt4, 1'b0, empty, full, busy};
            2'd2: data_rdata = {16'd0, div_q};
            2'd3: data_rdata = {31'd0, irq_en_q};
         endcase
      end
   end

   assign uart_tx = tx_q;
   assign irq     = irq_q;
endmodule

// File: tb/tb_dbus_uart_tx.sv
// Bench for dbus_uart_tx: bus stores push expected bytes to a scoreboard; a line receiver
// decodes uart_tx cycle by cycle and pops/compares each frame.
module tb_dbus_uart_tx;
   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam int DEPTH = 8;
   localparam int CPB   = 16;
   localparam logic [31:0] TXD = BASE, STS = BASE + 32'h4, DIVR = BASE + 32'h8, CTL = BASE + 32'hC;

   typedef struct {logic [7:0] b; int div;} exp_t;

   logic        clk = 1'b0, rst_n;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_we, data_re, hit, uart_tx, irq;

   exp_t sb[$];
   int   n_chk = 0, n_fail = 0;
   bit   rx_busy = 0;

   dbus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst_n(rst_n), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_we(data_we), .data_re(data_re), .data_rdata(data_rdata), .hit(hit),
      .uart_tx(uart_tx), .irq(irq));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the store commits on the next posedge and the task returns at the negedge after it.
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      data_addr = a; data_wdata = d; data_we = 1'b1;
      @(negedge clk);
      data_we = 1'b0; data_addr = '0;
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      data_addr = a; data_re = 1'b1;
      #1 chk(tag, data_rdata, exp);
      data_re = 1'b0; data_addr = '0;
   endtask

   task automatic send(input logic [7:0] b, input int div);
      sb.push_back('{b, div});
      bus_wr(TXD, {24'd0, b});
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((sb.size() != 0 || rx_busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()) + 32'(rx_busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Line receiver: checks every clock of each frame against the expected byte and bit period.
   initial begin : rx
      exp_t e;
      logic [7:0] got;
      logic lvl;
      int err, idx;
      bit ab;
      forever begin
         @(negedge clk);
         if (!rst_n && uart_tx === 1'b0) begin
            if (sb.size() == 0) begin
               chk("rx_unexpected", 32'd1, 32'd0);
               while (uart_tx === 1'b0 && !rst_n) @(negedge clk);
            end else begin
               e = sb.pop_front();
               rx_busy = 1; got = '0; err = 0; ab = 0;
               for (int k = 0; k < 10 * e.div; k++) begin
                  if (k != 0) begin
                     @(negedge clk);
                     if (rst_n) begin ab = 1; break; end
                  end
                  idx = k / e.div;
                  lvl = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : e.b[idx-1];
                  if (uart_tx !== lvl) err++;
                  if ((k % e.div) == (e.div / 2) && idx >= 1 && idx <= 8) got[idx-1] = uart_tx;
               end
               if (!ab) begin
                  chk("rx_byte", 32'(got), 32'(e.b));
                  chk("rx_shape", 32'(err), 32'd0);
               end
               rx_busy = 0;
            end
         end
      end
   end

`ifndef DBUS_UART_TX_IRQ_EN
   bit irq_mon = 0;
   int irq_hi = 0;
   always @(negedge clk) if (irq_mon && irq !== 1'b0) irq_hi++;
`endif

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : main
      int lows;
      rst_n = 1'b1; data_addr = '0; data_wdata = '0; data_we = 1'b0; data_re = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", uart_tx, 1'b1);
      chk("rst_irq", irq, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
`ifndef DBUS_UART_TX_IRQ_EN
      irq_mon = 1;
`endif
      rd_chk("rst_status", STS, 32'h004);
      rd_chk("rst_div", DIVR, CPB);
      rd_chk("rst_ctrl", CTL, 32'h0);

      // single frame, latency and length
      bus_wr(DIVR, 32'd4);
      send(8'h55, 4);
      chk("lat_pre", uart_tx, 1'b1);
      rd_chk("status_push", STS, 32'h010);
      @(negedge clk);
      chk("lat_fall", uart_tx, 1'b0);
      repeat (39) @(negedge clk);
      data_addr = STS; data_re = 1'b1;
      #1 chk("busy_last", data_rdata[0], 1'b1);
      data_re = 1'b0; data_addr = '0;
      @(negedge clk);
      rd_chk("status_done", STS, 32'h004);
      wait_drain(20);

      // burst of 10 stores: shifter + FIFO hold 9, tenth dropped
      for (int i = 0; i < 10; i++) begin
         if (i <= DEPTH) sb.push_back('{8'(i), 4});
         bus_wr(TXD, 32'(i));
      end
      rd_chk("status_full", STS, 32'h183);
      wait_drain(9 * 40 + 50);
      rd_chk("status_ovf", STS, 32'h104);
      bus_wr(STS, 32'h100);
      rd_chk("ovf_clr", STS, 32'h004);

      // register corner cases
      bus_wr(DIVR, 32'd0);
      rd_chk("div_zero", DIVR, 32'd1);
      rd_chk("misalign", BASE + 32'h9, 32'd1);
      rd_chk("txdata_rd", TXD, 32'd0);
      data_addr = 32'h2000_0004; data_re = 1'b1;
      #1 chk("miss_hit", hit, 1'b0);
      chk("miss_rdata", data_rdata, 32'd0);
      data_addr = STS; data_re = 1'b0;
      #1 chk("no_re_rdata", data_rdata, 32'd0);
      chk("in_hit", hit, 1'b1);
      data_addr = '0;
      @(negedge clk);

      // DIVISOR change mid-frame only applies to the next frame
      bus_wr(DIVR, 32'd4);
      send(8'hA5, 4);
      send(8'h3C, 8);
      repeat (10) @(negedge clk);
      bus_wr(DIVR, 32'd8);
      wait_drain(200);
      rd_chk("div8", DIVR, 32'd8);
      bus_wr(DIVR, 32'd4);

      // reset during data bit 3 with three bytes queued
      send(8'h00, 4);
      send(8'h11, 4);
      send(8'h22, 4);
      send(8'h33, 4);
      repeat (16) @(negedge clk);
      chk("pre_rst_tx", uart_tx, 1'b0);
      #2 rst_n = 1'b1;
      sb.delete();
      #1 chk("rst_async_tx", uart_tx, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rd_chk("post_rst_status", STS, 32'h004);
      rd_chk("post_rst_div", DIVR, CPB);
      lows = 0;
      repeat (100) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("post_rst_quiet", 32'(lows), 32'd0);

      bus_wr(DIVR, 32'd4);
`ifdef DBUS_UART_TX_IRQ_EN
      bus_wr(CTL, 32'd1);
      rd_chk("ctrl_rb", CTL, 32'd1);
      chk("irq_idle", irq, 1'b1);
      send(8'h81, 4);
      chk("irq_push_fall", irq, 1'b0);
      repeat (40) @(negedge clk);
      chk("irq_in_frame", irq, 1'b0);
      @(negedge clk);
      chk("irq_rise", irq, 1'b1);
      wait_drain(20);
      send(8'h7E, 4);
      chk("irq_push_fall2", irq, 1'b0);
      wait_drain(60);
      chk("irq_end", irq, 1'b1);
`else
      bus_wr(CTL, 32'd1);
      rd_chk("ctrl_ignored", CTL, 32'd0);
      send(8'h81, 4);
      wait_drain(60);
      chk("irq_never", 32'(irq_hi), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
